// File: rtl/branch_resolve_q.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_q
//  Description : Collects resolved branch/jump outcomes from the execute stage
//                and presents at most one mispredict to recovery_ctrl.
//                Predict-not-taken: every resolved-taken branch is a
//                mispredict. While one mispredict is being held, the oldest
//                strictly-older taken event is parked and issued after the
//                current flush completes. Younger or equal-age events are
//                dropped, because that flush kills them.
//
//  Parameters  : ROB_W          ROB tag width (age = (tag - rob_head_i) mod 2**ROB_W)
//
//  Ports       : clk            clock, all state on posedge
//                rst_n          asynchronous, active-low reset
//                br_valid_i     branch/jump resolved this cycle
//                br_taken_i     resolved taken
//                br_target_i    resolved target PC
//                br_tag_i       ROB tag of the branch
//                rob_head_i     current ROB head tag (oldest in flight)
//                flush_i        flush pulse from recovery_ctrl
//                mispredict_o   level to recovery_ctrl
//                target_pc_o    redirect PC, stable while mispredict_o=1
//                recover_tag_o  tag of mispredicting branch, stable while mispredict_o=1
//                busy_o         registered: state != IDLE or a parked event exists
//                mp_count_o     (BRQ_STATS_EN only) number of mispredicts issued
//                drop_count_o   (BRQ_STATS_EN only) number of taken events dropped
//
//  Config      : define BRQ_STATS_EN to add the two statistics counters.
//
//  Revision    : 1.0  initial release
// ============================================================================
module branch_resolve_q #(
    parameter int ROB_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid_i,
    input  logic             br_taken_i,
    input  logic [31:0]      br_target_i,
    input  logic [ROB_W-1:0] br_tag_i,
    input  logic [ROB_W-1:0] rob_head_i,
    input  logic             flush_i,
    output logic             mispredict_o,
    output logic [31:0]      target_pc_o,
    output logic [ROB_W-1:0] recover_tag_o,
    output logic             busy_o
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]      mp_count_o,
    output logic [31:0]      drop_count_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_mispredict;
    logic             r_busy;
    logic [31:0]      r_held_tgt;
    logic [ROB_W-1:0] r_held_tag;
    logic             r_pend_v;
    logic [31:0]      r_pend_tgt;
    logic [ROB_W-1:0] r_pend_tag;
    logic [ROB_W-1:0] r_last_tag;

    // ------------------------------------------------------------------------
    // Age comparison. All ages are taken relative to this cycle's ROB head so
    // tag wrap-around falls out of the modular subtraction. Equal age is
    // treated as "not older".
    // ------------------------------------------------------------------------
    logic             w_event;
    logic [ROB_W-1:0] w_age_evt;
    logic [ROB_W-1:0] w_age_held;
    logic [ROB_W-1:0] w_age_pend;
    logic [ROB_W-1:0] w_age_last;
    logic             w_older_held;
    logic             w_older_pend;
    logic             w_older_last;
    logic             w_pend_win;
    logic             w_hold_accept;
    logic             w_gap_accept;
    logic             w_gap_pend_v;
    logic [31:0]      w_gap_pend_tgt;
    logic [ROB_W-1:0] w_gap_pend_tag;

    assign w_event      = br_valid_i & br_taken_i;
    assign w_age_evt    = br_tag_i   - rob_head_i;
    assign w_age_held   = r_held_tag - rob_head_i;
    assign w_age_pend   = r_pend_tag - rob_head_i;
    assign w_age_last   = r_last_tag - rob_head_i;
    assign w_older_held = (w_age_evt < w_age_held);
    assign w_older_pend = (w_age_evt < w_age_pend);
    assign w_older_last = (w_age_evt < w_age_last);

    // Oldest-wins into the single parking slot.
    assign w_pend_win    = ~r_pend_v | w_older_pend;
    assign w_hold_accept = w_event & w_older_held & w_pend_win;
    assign w_gap_accept  = w_event & w_older_last & w_pend_win;

    // Parking slot contents after this cycle's merge in GAP; GAP decides
    // its next state from these so an event arriving in the GAP cycle
    // itself can be issued immediately afterwards.
    assign w_gap_pend_v   = r_pend_v | w_gap_accept;
    assign w_gap_pend_tgt = w_gap_accept ? br_target_i : r_pend_tgt;
    assign w_gap_pend_tag = w_gap_accept ? br_tag_i    : r_pend_tag;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mispredict <= 1'b0;
            r_busy       <= 1'b0;
            r_held_tgt   <= 32'd0;
            r_held_tag   <= '0;
            r_pend_v     <= 1'b0;
            r_pend_tgt   <= 32'd0;
            r_pend_tag   <= '0;
            r_last_tag   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Parking slot is always empty here: GAP only falls back
                    // to IDLE when nothing is parked. flush_i is ignored.
                    if (w_event) begin
                        r_held_tgt   <= br_target_i;
                        r_held_tag   <= br_tag_i;
                        r_mispredict <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    // Held values stay frozen: recovery_ctrl may sample them
                    // on any cycle while mispredict_o is high.
                    if (w_hold_accept) begin
                        r_pend_v   <= 1'b1;
                        r_pend_tgt <= br_target_i;
                        r_pend_tag <= br_tag_i;
                    end
                    if (flush_i) begin
                        r_last_tag   <= r_held_tag;
                        r_mispredict <= 1'b0;
                        r_state      <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    // One low cycle on mispredict_o so recovery_ctrl always
                    // sees a fresh rising edge for the next mispredict.
                    if (w_gap_pend_v) begin
                        r_held_tgt   <= w_gap_pend_tgt;
                        r_held_tag   <= w_gap_pend_tag;
                        r_pend_v     <= 1'b0;
                        r_mispredict <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_HOLD;
                    end else begin
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_mispredict <= 1'b0;
                    r_busy       <= 1'b0;
                    r_pend_v     <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign mispredict_o  = r_mispredict;
    assign target_pc_o   = r_held_tgt;
    assign recover_tag_o = r_held_tag;
    assign busy_o        = r_busy;

`ifdef BRQ_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics. A taken event counts as dropped when it does not end up in
    // the parking slot (too young, or beaten by an older parked event).
    // ------------------------------------------------------------------------
    logic        w_enter_hold;
    logic        w_drop;
    logic [31:0] r_mp_count;
    logic [31:0] r_drop_count;

    assign w_enter_hold = ((r_state == ST_IDLE) & w_event) |
                          ((r_state == ST_GAP)  & w_gap_pend_v);
    assign w_drop       = ((r_state == ST_HOLD) & w_event & ~w_hold_accept) |
                          ((r_state == ST_GAP)  & w_event & ~w_gap_accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mp_count   <= 32'd0;
            r_drop_count <= 32'd0;
        end else begin
            if (w_enter_hold) begin
                r_mp_count <= r_mp_count + 32'd1;
            end
            if (w_drop) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    assign mp_count_o   = r_mp_count;
    assign drop_count_o = r_drop_count;
`endif

endmodule
`default_nettype wire
